// File: rtl/pixel_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fetch_responder_pkg
// Description : Shared types, default widths and a constant clog2 helper for
//               the pixel fetch responder and its request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_fetch_responder_pkg;

  // Default widths of the controller's fetch port.
  localparam int DEFAULT_ADDRESS_WIDTH = 25;
  localparam int PIXEL_WIDTH           = 8;

  // Memory issue state machine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } issue_state_e;

  // Ceiling log2, usable in constant expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fetch_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a combinational head (pop_data shows
//               the oldest entry whenever the FIFO is non-empty). A push when
//               full and a pop when empty are ignored.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push, push_data - write strobe and data
//               pop, pop_data   - read strobe and head entry
//               full, empty     - occupancy flags
//               count           - current number of entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import pixel_fetch_responder_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 8,
  localparam int PTR_W   = clog2(DEPTH),
  localparam int COUNT_W = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] DEPTH_COUNT = COUNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push_en;
  logic               pop_en;

  assign full     = (count_q == DEPTH_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_en  = push & ~full;
  assign pop_en   = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fetch_responder
// Description : Responder end of the LED matrix controller's pixel fetch
//               port. Queues byte read requests, issues them to a pipelined
//               memory port (accept/return handshakes, in-order returns) and
//               hands the bytes back to the controller in request order.
// Ports       : clk, reset                 - clock, synchronous active-high reset
//               address_fifo               - request address from controller
//               data_out_ready_fifo        - request strobe
//               fifo_full                  - registered almost-full flag
//               data_in_fifo, data_in_ready_fifo - returned byte and strobe
//               mem_addr, mem_rd, mem_ack  - memory request handshake
//               mem_rdata, mem_rvalid      - memory return
//               overflow_err               - sticky queue-overflow / stray-return flag
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fetch_responder
  import pixel_fetch_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FULL_MARGIN     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address_fifo,
  input  logic                     data_out_ready_fifo,
  output logic                     fifo_full,
  output logic [PIXEL_WIDTH-1:0]   data_in_fifo,
  output logic                     data_in_ready_fifo,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd,
  input  logic                     mem_ack,
  input  logic [PIXEL_WIDTH-1:0]   mem_rdata,
  input  logic                     mem_rvalid,
  output logic                     overflow_err
);

  localparam int COUNT_W = clog2(QUEUE_DEPTH + 1);
  localparam int OUT_W   = clog2(MAX_OUTSTANDING + 1);
  localparam logic [COUNT_W-1:0] FULL_LEVEL = COUNT_W'(QUEUE_DEPTH - FULL_MARGIN);
  localparam logic [OUT_W:0]     OUT_LIMIT  = (OUT_W + 1)'(MAX_OUTSTANDING);

  // Request queue
  logic                     q_push;
  logic                     q_pop;
  logic                     q_full;
  logic                     q_empty;
  logic [COUNT_W-1:0]       q_count;
  logic [ADDRESS_WIDTH-1:0] q_head;
  logic [COUNT_W-1:0]       count_next;

  // Issue and return tracking
  issue_state_e             state_q, state_d;
  logic [OUT_W-1:0]         outstanding_q, outstanding_d;
  logic [OUT_W-1:0]         drain_q, drain_d, drain_capture;
  logic [OUT_W:0]           outstanding_ext;
  logic                     accept;
  logic                     ret_discard;
  logic                     ret_valid;
  logic                     ret_stray;

  // Registered controller-facing outputs
  logic                     fifo_full_q, fifo_full_d;
  logic [PIXEL_WIDTH-1:0]   data_in_fifo_q, data_in_fifo_d;
  logic                     data_in_ready_q, data_in_ready_d;
  logic                     overflow_err_q, overflow_err_d;

  sync_fifo #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (address_fifo),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // mem_rd and mem_addr decode straight from state and queue flops, so they
  // hold steady for the whole ISSUE cycle and read 0 everywhere else.
  assign mem_rd   = (state_q == ISSUE);
  assign mem_addr = mem_rd ? q_head : '0;

  assign q_push = data_out_ready_fifo & ~q_full;
  assign accept = mem_rd & mem_ack;
  assign q_pop  = accept;

  // Returns for reads that were in flight when reset hit are drained first;
  // they are older than anything issued afterwards because returns are in order.
  assign ret_discard = mem_rvalid & (drain_q != '0);
  assign ret_valid   = mem_rvalid & (drain_q == '0) & (outstanding_q != '0);
  assign ret_stray   = mem_rvalid & (drain_q == '0) & (outstanding_q == '0);

  assign outstanding_ext = {1'b0, outstanding_q};

  always_comb begin
    count_next = q_count;
    if (q_push) begin
      count_next = count_next + COUNT_W'(1);
    end
    if (q_pop) begin
      count_next = count_next - COUNT_W'(1);
    end
  end

  // Issue state machine
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!q_empty && (outstanding_ext < OUT_LIMIT)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          if ((count_next != '0) && ((outstanding_ext + (OUT_W + 1)'(1)) < OUT_LIMIT)) begin
            state_d = ISSUE;
          end else if (count_next != '0) begin
            state_d = STALL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STALL: begin
        if (ret_valid) begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outstanding_d   = outstanding_q + OUT_W'(accept) - OUT_W'(ret_valid);
    drain_d         = drain_q - OUT_W'(ret_discard);
    // Reads the memory still owes us at the moment reset is sampled.
    drain_capture   = outstanding_q + OUT_W'(accept);
    fifo_full_d     = (count_next >= FULL_LEVEL);
    data_in_fifo_d  = ret_valid ? mem_rdata : data_in_fifo_q;
    data_in_ready_d = ret_valid;
    overflow_err_d  = overflow_err_q | ret_stray | (data_out_ready_fifo & q_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      outstanding_q   <= '0;
      drain_q         <= drain_capture;
      fifo_full_q     <= 1'b0;
      data_in_fifo_q  <= '0;
      data_in_ready_q <= 1'b0;
      overflow_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      outstanding_q   <= outstanding_d;
      drain_q         <= drain_d;
      fifo_full_q     <= fifo_full_d;
      data_in_fifo_q  <= data_in_fifo_d;
      data_in_ready_q <= data_in_ready_d;
      overflow_err_q  <= overflow_err_d;
    end
  end

  assign fifo_full          = fifo_full_q;
  assign data_in_fifo       = data_in_fifo_q;
  assign data_in_ready_fifo = data_in_ready_q;
  assign overflow_err       = overflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_fetch_responder
// Description : Directed self-checking bench for pixel_fetch_responder with a
//               small in-order memory model (fixed latency, byte = addr ^ 0xFC).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_fetch_responder;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address_fifo = '0;
  logic          data_out_ready_fifo = 1'b0;
  logic          fifo_full;
  logic [7:0]    data_in_fifo;
  logic          data_in_ready_fifo;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic          mem_rvalid = 1'b0;
  logic          overflow_err;

  pixel_fetch_responder #(
    .ADDRESS_WIDTH   (AW),
    .QUEUE_DEPTH     (8),
    .MAX_OUTSTANDING (4),
    .FULL_MARGIN     (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .address_fifo        (address_fifo),
    .data_out_ready_fifo (data_out_ready_fifo),
    .fifo_full           (fifo_full),
    .data_in_fifo        (data_in_fifo),
    .data_in_ready_fifo  (data_in_ready_fifo),
    .mem_addr            (mem_addr),
    .mem_rd              (mem_rd),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .mem_rvalid          (mem_rvalid),
    .overflow_err        (overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model and monitor (negedge + 1) ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
  } pend_t;

  pend_t         pend[$];
  pend_t         pend_tmp;
  logic [AW-1:0] acc_addr[$];
  int            acc_cyc[$];
  int            ret_cyc[$];
  logic [7:0]    rx[$];
  int            rx_cyc[$];
  int            rd_hi = 0;
  bit            ack_en = 1'b0;
  int            acc_limit = -1;
  int            lat = 2;
  int            stray_req = 0;
  int            stray_done = 0;

  always begin
    @(negedge clk);
    #1;
    if (data_in_ready_fifo === 1'b1) begin
      rx.push_back(data_in_fifo);
      rx_cyc.push_back(cyc);
    end
    if (mem_rd === 1'b1) rd_hi++;
    mem_ack = ack_en && (acc_limit < 0 || acc_addr.size() < acc_limit);
    if (mem_rd === 1'b1 && mem_ack) begin
      pend_tmp.due  = cyc + lat;
      pend_tmp.data = mem_addr[7:0] ^ 8'hFC;
      pend.push_back(pend_tmp);
      acc_addr.push_back(mem_addr);
      acc_cyc.push_back(cyc);
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
      void'(pend.pop_front());
      ret_cyc.push_back(cyc);
    end else if (stray_req != stray_done) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h33;
      stray_done++;
    end else begin
      mem_rvalid = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx.size()) return 32'(rx[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_addr.size()) return 32'(acc_addr[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // Main thread works at negedge + 2: after the model has updated.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_cyc.delete();
    ret_cyc.delete();
    rx.delete();
    rx_cyc.delete();
    rd_hi = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ticks(n);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic send(input logic [AW-1:0] addr);
    address_fifo        = addr;
    data_out_ready_fifo = 1'b1;
    tick();
    data_out_ready_fifo = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(rx.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end, expected end of test");
    $fatal(1);
  end

  initial begin
    int req_c;
    int sent;
    int k;
    logic [AW-1:0] a;

    // ---- reset values ----
    do_reset(3);
    check_eq("rst_mem_rd", 32'(mem_rd), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_fifo_full", 32'(fifo_full), 0);
    check_eq("rst_rdy", 32'(data_in_ready_fifo), 0);
    check_eq("rst_data", 32'(data_in_fifo), 0);
    check_eq("rst_overflow", 32'(overflow_err), 0);

    // ---- single request, latency 3 ----
    lat    = 3;
    ack_en = 1'b1;
    req_c  = cyc;
    send(25'h0000A0);
    ticks(15);
    check_eq("t1_accepts", 32'(acc_addr.size()), 1);
    check_eq("t1_addr", acc_at(0), 32'h0000A0);
    check_eq("t1_rd_cycles", 32'(rd_hi), 1);
    check_eq("t1_strobes", 32'(rx.size()), 1);
    check_eq("t1_byte", rx_at(0), 32'h5C);
    // Request sampled at the end of its cycle; strobe 5 edges later.
    check_eq("t1_latency", (rx_cyc.size() > 0) ? 32'(rx_cyc[0] - req_c) : 32'hDEAD_BEEF, 6);

    // ---- burst of 16 honouring fifo_full, latency 2 ----
    do_reset(2);
    lat    = 2;
    ack_en = 1'b1;
    sent   = 0;
    k      = 0;
    while (sent < 16 && k < 200) begin
      if (!fifo_full) begin
        address_fifo        = AW'(32'h100 + sent * 3);
        data_out_ready_fifo = 1'b1;
        sent++;
      end else begin
        data_out_ready_fifo = 1'b0;
      end
      tick();
      k++;
    end
    data_out_ready_fifo = 1'b0;
    wait_rx(16, 100, "t2_count");
    for (int i = 0; i < 16; i++) begin
      a = AW'(32'h100 + i * 3);
      check_eq($sformatf("t2_byte%0d", i), rx_at(i), 32'(a[7:0] ^ 8'hFC));
    end
    check_eq("t2_overflow", 32'(overflow_err), 0);

    // ---- memory stalled, 9 requests ignoring fifo_full ----
    do_reset(2);
    lat    = 2;
    ack_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(AW'(32'h200 + i));
      data_out_ready_fifo = 1'b1;
      if (i == 4) check_eq("t3_full_at5", 32'(fifo_full), 0);
      if (i == 5) check_eq("t3_full_at6", 32'(fifo_full), 1);
      if (i == 7) check_eq("t3_no_ovf_at8", 32'(overflow_err), 0);
    end
    data_out_ready_fifo = 1'b0;
    check_eq("t3_overflow", 32'(overflow_err), 1);
    tick();
    ack_en = 1'b1;
    wait_rx(8, 100, "t3_count");
    check_eq("t3_accepts", 32'(acc_addr.size()), 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t3_addr%0d", i), acc_at(i), 32'h200 + i);
    end

    // ---- outstanding limit, latency 20 ----
    do_reset(2);
    lat    = 20;
    ack_en = 1'b1;
    for (int i = 0; i < 6; i++) send(AW'(32'h300 + i));
    ticks(12);
    check_eq("t4_accepts", 32'(acc_addr.size()), 4);
    check_eq("t4_stall_rd", 32'(mem_rd), 0);
    k = 0;
    while (acc_addr.size() < 5 && k < 40) begin
      tick();
      k++;
    end
    check_eq("t4_fifth_issue",
             (acc_cyc.size() > 4 && ret_cyc.size() > 0) ? 32'(acc_cyc[4] - ret_cyc[0]) : 32'hDEAD_BEEF, 1);
    wait_rx(6, 100, "t4_count");

    // ---- unsolicited return ----
    do_reset(2);
    stray_req++;
    ticks(4);
    check_eq("t5_no_strobe", 32'(rx.size()), 0);
    check_eq("t5_overflow", 32'(overflow_err), 1);

    // ---- reset with 3 queued and 2 outstanding ----
    do_reset(2);
    lat       = 20;
    ack_en    = 1'b1;
    acc_limit = 2;
    for (int i = 0; i < 5; i++) send(AW'(32'h400 + i));
    ticks(3);
    check_eq("t6_two_out", 32'(acc_addr.size()), 2);
    check_eq("t6_rd_pending", 32'(mem_rd), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_mem_rd", 32'(mem_rd), 0);
    check_eq("t6_mem_addr", 32'(mem_addr), 0);
    check_eq("t6_fifo_full", 32'(fifo_full), 0);
    check_eq("t6_rdy", 32'(data_in_ready_fifo), 0);
    check_eq("t6_overflow", 32'(overflow_err), 0);
    acc_limit = -1;
    rx.delete();
    rd_hi = 0;
    ticks(30);
    check_eq("t6_queue_empty", 32'(rd_hi), 0);
    check_eq("t6_stray_strobes", 32'(rx.size()), 0);
    check_eq("t6_stray_no_err", 32'(overflow_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
